capture_writer: RTL and testbench

- Write-side companion to the signal-generator address counters. Accepts a sample stream and writes it into a 2^ADDR_WIDTH-entry circular dual-port RAM. The read-side counters later replay the stored waveform from that RAM.
- Works like a scope capture: pre-trigger circular recording while armed, then a programmable number of post-trigger samples, then it stops.
- Reports the trigger address so readers can replay aligned to the trigger.

---
 rtl/capture_writer.sv | 87 ++++++++
 tb/tb_capture_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/capture_writer.sv
// Scope-style capture into a circular write port: pre-trigger recording while armed,
// then a programmable number of post-trigger samples, then hold for readers.
module capture_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  trig,
  input  logic [ADDR_WIDTH:0]   post_len,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_full
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] POST  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  accept;

  assign sample_ready = (state == ARMED) || (state == POST);
  assign busy         = sample_ready;
  assign done         = (state == DONE);
  assign accept       = sample_valid & sample_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      trig_addr <= '0;
      buf_full  <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= wr_ptr;
        wr_data <= sample_data;
        wr_ptr  <= wr_ptr + 1'b1;
        if (wr_ptr == '1)
          buf_full <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state    <= ARMED;
            wr_ptr   <= '0;
            buf_full <= 1'b0;
          end
        end
        ARMED: begin
          // A sample accepted in the trigger cycle is still pre-trigger.
          if (trig) begin
            trig_addr <= wr_ptr + ADDR_WIDTH'(accept);
            remaining <= post_len;
            state     <= (post_len == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_WIDTH+1)'(1))
              state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_writer.sv
// Directed bench for capture_writer: expected RAM writes are queued by the stimulus
// and popped by an independent write monitor; status outputs are checked inline.
module tb_capture_writer;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, arm, trig, sample_valid;
  logic [AW:0]   post_len;
  logic [DW-1:0] sample_data;
  logic          sample_ready, wr_en, busy, done, buf_full;
  logic [AW-1:0] wr_addr, trig_addr;
  logic [DW-1:0] wr_data;

  capture_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .post_len(post_len),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .trig_addr(trig_addr), .busy(busy), .done(done),
    .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one cycle; valid stays high so calls can stream back-to-back.
  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a);
    sample_valid = 1'b1;
    sample_data  = d;
    exp_q.push_back('{addr: a, data: d});
    cyc();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {28'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; trig = 1'b0; post_len = '0;
    sample_valid = 1'b1; sample_data = 8'h5A;

    // Reset with a live input stream
    cyc(); cyc();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_busy_done_full_ready", {busy, done, buf_full, sample_ready}, 0);
    rst = 1'b0; sample_valid = 1'b0;
    cyc();
    chk("idle_ready", sample_ready, 0);

    // Basic capture
    do_arm();
    chk("armed_busy_ready", {busy, sample_ready, done}, 3'b110);
    for (int i = 0; i < 5; i++) send(DW'(8'h10 + i), AW'(i));
    sample_valid = 1'b0; trig = 1'b1; post_len = 5'd3;
    cyc();
    trig = 1'b0;
    chk("basic_trig_addr", trig_addr, 5);
    chk("basic_post_busy", busy, 1);
    for (int i = 5; i < 8; i++) send(DW'(8'h10 + i), AW'(i));
    chk("basic_done", done, 1);
    chk("basic_ready_low", sample_ready, 0);
    sample_data = 8'hAA;
    cyc(); cyc();
    sample_valid = 1'b0;
    chk("basic_done_hold", {done, busy}, 2'b10);

    // Wrap and buf_full
    do_arm();
    chk("wrap_full_cleared", buf_full, 0);
    chk("wrap_done_cleared", done, 0);
    for (int i = 0; i < 20; i++) begin
      send(DW'(i), AW'(i % 16));
      if (i == 14) chk("wrap_full_before", buf_full, 0);
      if (i == 15) chk("wrap_full_rise", buf_full, 1);
    end
    sample_valid = 1'b0; trig = 1'b1; post_len = 5'd1;
    cyc();
    trig = 1'b0;
    chk("wrap_trig_addr", trig_addr, 4);
    send(8'h55, 4'd4);
    sample_valid = 1'b0;
    chk("wrap_done", done, 1);
    chk("wrap_full_hold", buf_full, 1);

    // Trigger coinciding with an accept, zero post length
    do_arm();
    send(8'hA0, 4'd0);
    send(8'hA1, 4'd1);
    trig = 1'b1; post_len = 5'd0;
    send(8'hA2, 4'd2);
    trig = 1'b0;
    chk("twa_trig_addr", trig_addr, 3);
    chk("twa_done", done, 1);
    cyc(); cyc();
    sample_valid = 1'b0;

    // Valid gaps during POST
    do_arm();
    trig = 1'b1; post_len = 5'd2;
    cyc();
    trig = 1'b0;
    chk("gap_trig_addr", trig_addr, 0);
    send(8'hB0, 4'd0);
    sample_valid = 1'b0;
    chk("gap_not_done", done, 0);
    cyc();
    chk("gap_wr_en_0a", wr_en, 0);
    cyc();
    chk("gap_wr_en_0b", wr_en, 0);
    send(8'hB1, 4'd1);
    sample_valid = 1'b0;
    chk("gap_done", done, 1);

    // Reset mid-POST then rearm
    do_arm();
    trig = 1'b1; post_len = 5'd5;
    cyc();
    trig = 1'b0;
    send(8'hC0, 4'd0);
    sample_valid = 1'b0;
    rst = 1'b1; arm = 1'b1; trig = 1'b1;
    cyc(); cyc();
    chk("mid_rst_state", {busy, done, sample_ready, wr_en}, 0);
    chk("mid_rst_trig_addr", trig_addr, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    rst = 1'b0; arm = 1'b0; trig = 1'b0;
    cyc();
    chk("mid_rst_idle", busy, 0);
    do_arm();
    chk("rearm_busy_done", {busy, done}, 2'b10);
    send(8'hD0, 4'd0);
    sample_valid = 1'b0;
    chk("rearm_buf_full", buf_full, 0);
    chk("rearm_done", done, 0);
    cyc(); cyc(); cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
